// File: rtl/fwd_select_unit.sv
// EX-stage operand forwarding select and load-use stall generator for a 5-stage pipeline.
// Optional statistics counters are enabled with `define FWD_SELECT_STATS_EN.
module fwd_select_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned STAT_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  load_use_stall
`ifdef FWD_SELECT_STATS_EN
    ,
    output logic [STAT_W-1:0]     fwd_count,
    output logic [STAT_W-1:0]     stall_count
`endif
);

    localparam logic [1:0] SelRf  = 2'b00;
    localparam logic [1:0] SelWb  = 2'b01;
    localparam logic [1:0] SelMem = 2'b10;

    if (STAT_W == 0) begin : g_bad_stat_w
        $error("STAT_W must be non-zero");
    end

    // Stage records
    logic                  ex_v_q, ex_we_q, ex_mr_q;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic                  mem_v_q, mem_we_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  wb_v_q, wb_we_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;

    logic mem_wr_live, wb_wr_live;
    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic ex_bubble;

    // A stage only forwards if it really writes a non-zero register.
    assign mem_wr_live = mem_v_q & mem_we_q & (mem_rd_q != '0);
    assign wb_wr_live  = wb_v_q & wb_we_q & (wb_rd_q != '0);

    assign mem_hit_a = mem_wr_live & (mem_rd_q == ex_rs1_q);
    assign mem_hit_b = mem_wr_live & (mem_rd_q == ex_rs2_q);
    assign wb_hit_a  = wb_wr_live & (wb_rd_q == ex_rs1_q);
    assign wb_hit_b  = wb_wr_live & (wb_rd_q == ex_rs2_q);

    always_comb begin
        fwd_a_sel = SelRf;
        fwd_b_sel = SelRf;
        if (ex_v_q) begin
            if (mem_hit_a) begin
                fwd_a_sel = SelMem;
            end else if (wb_hit_a) begin
                fwd_a_sel = SelWb;
            end
            if (mem_hit_b) begin
                fwd_b_sel = SelMem;
            end else if (wb_hit_b) begin
                fwd_b_sel = SelWb;
            end
        end
    end

    // Both sources are compared even if the ID instruction does not use rs2.
    assign load_use_stall = id_valid & ~flush & ex_v_q & ex_we_q & ex_mr_q &
                            (ex_rd_q != '0) & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

    assign ex_bubble = flush | load_use_stall | ~id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_v_q   <= 1'b0;
            ex_we_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            ex_rd_q  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            mem_v_q  <= 1'b0;
            mem_we_q <= 1'b0;
            mem_rd_q <= '0;
            wb_v_q   <= 1'b0;
            wb_we_q  <= 1'b0;
            wb_rd_q  <= '0;
        end else if (!hold) begin
            wb_v_q   <= mem_v_q;
            wb_we_q  <= mem_we_q;
            wb_rd_q  <= mem_rd_q;
            mem_v_q  <= ex_v_q;
            mem_we_q <= ex_we_q;
            mem_rd_q <= ex_rd_q;
            ex_rd_q  <= id_rd;
            ex_rs1_q <= id_rs1;
            ex_rs2_q <= id_rs2;
            if (ex_bubble) begin
                ex_v_q  <= 1'b0;
                ex_we_q <= 1'b0;
                ex_mr_q <= 1'b0;
            end else begin
                ex_v_q  <= 1'b1;
                ex_we_q <= id_reg_write;
                ex_mr_q <= id_mem_read;
            end
        end
    end

`ifdef FWD_SELECT_STATS_EN
    logic [STAT_W-1:0] fwd_count_q, stall_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else if (!hold) begin
            if (ex_v_q && (fwd_a_sel != SelRf || fwd_b_sel != SelRf)) begin
                fwd_count_q <= fwd_count_q + 1'b1;
            end
            if (load_use_stall) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign fwd_count   = fwd_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
